fft_sequencer: RTL and testbench

Upstream controller for the 16-point radix-4 FFT datapath. It collects 16 complex samples from a serial source and issues them to the `butterfly` stage as four 4-sample groups with rotation codes 000–011 (stage 1). It stores the four stage-1 results and feeds them back with rotation codes 100–111 (stage 2). Each stage-2 result is forwarded downstream as one output group.

---
 rtl/fft_pkg.sv | 68 ++++++
 rtl/fft_sequencer_if.sv | 30 +++
 rtl/fft_tag_delay.sv | 28 ++
 rtl/fft_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared widths, slot layout, rotation codes, FSM state and tracker tag
// for the 16-point radix-4 FFT sequencer.
package fft_pkg;

    localparam int DATA_W  = 17;
    localparam int CPLX_W  = 2 * DATA_W;
    localparam int GROUP_W = 4 * CPLX_W;
    localparam int N_PT    = 16;

    // Slot 0 sits in the most significant position of a group word.
    localparam int SLOT0_LSB = 3 * CPLX_W;
    localparam int SLOT1_LSB = 2 * CPLX_W;
    localparam int SLOT2_LSB = 1 * CPLX_W;
    localparam int SLOT3_LSB = 0;

    localparam logic [2:0] ROT_S1_0 = 3'b000;
    localparam logic [2:0] ROT_S1_1 = 3'b001;
    localparam logic [2:0] ROT_S1_2 = 3'b010;
    localparam logic [2:0] ROT_S1_3 = 3'b011;
    localparam logic [2:0] ROT_S2_0 = 3'b100;
    localparam logic [2:0] ROT_S2_1 = 3'b101;
    localparam logic [2:0] ROT_S2_2 = 3'b110;
    localparam logic [2:0] ROT_S2_3 = 3'b111;

    typedef logic [CPLX_W-1:0]  cplx_t;
    typedef logic [GROUP_W-1:0] group_t;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_S1_ISSUE = 3'd1,
        ST_S1_DRAIN = 3'd2,
        ST_S2_ISSUE = 3'd3,
        ST_S2_DRAIN = 3'd4
    } fft_state_e;

    // Travels alongside a butterfly issue so its result can be routed back.
    typedef struct packed {
        logic       valid;
        logic       stage;
        logic [1:0] k;
    } fft_tag_t;

    function automatic group_t pack_group(cplx_t s0, cplx_t s1, cplx_t s2, cplx_t s3);
        group_t g;
        g = '0;
        g[SLOT0_LSB +: CPLX_W] = s0;
        g[SLOT1_LSB +: CPLX_W] = s1;
        g[SLOT2_LSB +: CPLX_W] = s2;
        g[SLOT3_LSB +: CPLX_W] = s3;
        return g;
    endfunction

    function automatic logic [2:0] rot_code(logic stage, logic [1:0] k);
        logic [2:0] r;
        case ({stage, k})
            3'b000:  r = ROT_S1_0;
            3'b001:  r = ROT_S1_1;
            3'b010:  r = ROT_S1_2;
            3'b011:  r = ROT_S1_3;
            3'b100:  r = ROT_S2_0;
            3'b101:  r = ROT_S2_1;
            3'b110:  r = ROT_S2_2;
            default: r = ROT_S2_3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Bundle of the sample input, butterfly and output-group signals.
// Input handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high; in_data must be stable while in_valid is high and
// the source must not drop a pending sample before it transfers. The
// butterfly path and the output group have no handshake: calc_out is trusted
// BF_LATENCY cycles after issue and every out_valid pulse must be consumed.
interface fft_sequencer_if;
    import fft_pkg::*;

    logic       in_valid;
    logic       in_ready;
    cplx_t      in_data;
    group_t     calc_in;
    logic [2:0] rotation;
    group_t     calc_out;
    logic       out_valid;
    group_t     out_data;
    logic [1:0] out_group;

    modport master (
        input  in_valid, in_data, calc_out,
        output in_ready, calc_in, rotation, out_valid, out_data, out_group
    );

    modport slave (
        output in_valid, in_data, calc_out,
        input  in_ready, calc_in, rotation, out_valid, out_data, out_group
    );

endinterface

// File: rtl/fft_tag_delay.sv
// Fixed-depth shift register that delays an issue tag by the butterfly
// latency so the tag emerges in the same cycle as the matching result.
module fft_tag_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  fft_tag_t tag_i,
    output fft_tag_t tag_o
);

    fft_tag_t pipe_q [DEPTH];

    // Shift tags one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Collects 16 complex samples, issues them to the butterfly as four stage-1
// groups, feeds the stored stage-1 results back as four stage-2 groups and
// forwards each stage-2 result as an output group. Data passes bit-exact.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int BF_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fft_sequencer_if.master        bus,
    output fft_state_e             dbg_state_o
);

    fft_state_e state_q;
    logic [3:0] cnt_q;
    logic [1:0] k_q;
    cplx_t      sbuf_q [N_PT];
    group_t     ibuf_q [4];

    logic       in_ready_q;
    group_t     calc_in_q;
    logic [2:0] rotation_q;
    logic       out_valid_q;
    group_t     out_data_q;
    logic [1:0] out_group_q;

    fft_tag_t   tag_d;
    fft_tag_t   tag_out;
    logic [1:0] sel_k;
    group_t     s1_grp;
    group_t     s2_grp;
    logic       accept;
    logic       s1_last_done;

    assign accept       = in_ready_q & bus.in_valid;
    assign s1_last_done = tag_out.valid & ~tag_out.stage & (tag_out.k == 2'd3);

    // Tag for the group currently on calc_in; only issue states produce one.
    always_comb begin
        tag_d       = '0;
        tag_d.valid = (state_q == ST_S1_ISSUE) || (state_q == ST_S2_ISSUE);
        tag_d.stage = (state_q == ST_S2_ISSUE);
        tag_d.k     = k_q;
    end

    // Group index to load into calc_in at the coming edge: next k while
    // issuing, group 0 when entering an issue state.
    always_comb begin
        sel_k = 2'd0;
        if ((state_q == ST_S1_ISSUE) || (state_q == ST_S2_ISSUE)) sel_k = k_q + 2'd1;
    end

    assign s1_grp = pack_group(sbuf_q[{sel_k, 2'd0}], sbuf_q[{sel_k, 2'd1}],
                               sbuf_q[{sel_k, 2'd2}], sbuf_q[{sel_k, 2'd3}]);
    assign s2_grp = ibuf_q[sel_k];

    fft_tag_delay #(.DEPTH(BF_LATENCY)) u_tag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_d),
        .tag_o (tag_out)
    );

    // Sample buffer: each accepted beat lands at the current load position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PT; i++) sbuf_q[i] <= '0;
        end else if (accept) begin
            sbuf_q[cnt_q] <= bus.in_data;
        end
    end

    // Intermediate buffer: stage-1 results captured as their tags emerge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ibuf_q[i] <= '0;
        end else if (tag_out.valid && !tag_out.stage) begin
            ibuf_q[tag_out.k] <= bus.calc_out;
        end
    end

    // Frame FSM with all handshake, butterfly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= 4'd0;
            k_q         <= 2'd0;
            in_ready_q  <= 1'b1;
            calc_in_q   <= '0;
            rotation_q  <= ROT_S1_0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_group_q <= 2'd0;
        end else begin
            out_valid_q <= 1'b0;
            if (tag_out.valid && tag_out.stage) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.calc_out;
                out_group_q <= tag_out.k;
            end
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q    <= ST_S1_ISSUE;
                            in_ready_q <= 1'b0;
                            k_q        <= 2'd0;
                            calc_in_q  <= s1_grp;
                            rotation_q <= rot_code(1'b0, 2'd0);
                        end
                    end
                end
                ST_S1_ISSUE: begin
                    if (k_q == 2'd3) begin
                        state_q    <= ST_S1_DRAIN;
                        k_q        <= 2'd0;
                        calc_in_q  <= '0;
                        rotation_q <= ROT_S1_0;
                    end else begin
                        k_q        <= sel_k;
                        calc_in_q  <= s1_grp;
                        rotation_q <= rot_code(1'b0, sel_k);
                    end
                end
                ST_S1_DRAIN: begin
                    if (s1_last_done) begin
                        state_q    <= ST_S2_ISSUE;
                        k_q        <= 2'd0;
                        calc_in_q  <= s2_grp;
                        rotation_q <= rot_code(1'b1, 2'd0);
                    end
                end
                ST_S2_ISSUE: begin
                    if (k_q == 2'd3) begin
                        state_q    <= ST_S2_DRAIN;
                        k_q        <= 2'd0;
                        calc_in_q  <= '0;
                        rotation_q <= ROT_S1_0;
                    end else begin
                        k_q        <= sel_k;
                        calc_in_q  <= s2_grp;
                        rotation_q <= rot_code(1'b1, sel_k);
                    end
                end
                ST_S2_DRAIN: begin
                    // Reopen input the cycle after the last group is presented.
                    if (out_valid_q && (out_group_q == 2'd3)) begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_LOAD;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.calc_in   = calc_in_q;
    assign bus.rotation  = rotation_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_group = out_group_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: main instance at BF_LATENCY=2 plus instances at 1
// and 5 for latency timing; each has a butterfly stub that echoes calc_in.
module tb_fft_sequencer;
    import fft_pkg::*;

    localparam int L = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic  drv_valid = 1'b0;
    cplx_t drv_data  = '0;

    fft_sequencer_if bus1 ();
    fft_sequencer_if bus2 ();
    fft_sequencer_if bus5 ();
    fft_state_e dbg1, dbg2, dbg5;

    assign bus1.in_valid = drv_valid;
    assign bus2.in_valid = drv_valid;
    assign bus5.in_valid = drv_valid;
    assign bus1.in_data  = drv_data;
    assign bus2.in_data  = drv_data;
    assign bus5.in_data  = drv_data;

    fft_sequencer #(.BF_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master), .dbg_state_o(dbg1));
    fft_sequencer #(.BF_LATENCY(L)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master), .dbg_state_o(dbg2));
    fft_sequencer #(.BF_LATENCY(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.master), .dbg_state_o(dbg5));

    // Butterfly stubs: pure delay lines of the requested latency.
    group_t echo1_q [1];
    group_t echo2_q [2];
    group_t echo5_q [5];
    always @(posedge clk) begin
        echo1_q[0] <= bus1.calc_in;
        echo2_q[0] <= bus2.calc_in;
        echo2_q[1] <= echo2_q[0];
        echo5_q[0] <= bus5.calc_in;
        for (int i = 1; i < 5; i++) echo5_q[i] <= echo5_q[i-1];
    end
    assign bus1.calc_out = echo1_q[0];
    assign bus2.calc_out = echo2_q[1];
    assign bus5.calc_out = echo5_q[4];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [GROUP_W-1:0] exp_q[$];
    logic [1:0]         exp_grp_q[$];

    always @(negedge clk) begin
        if (bus2.out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_out", 136'(1), 136'(0));
            end else begin
                check_eq("out_data", bus2.out_data, exp_q.pop_front());
                check_eq("out_group", 136'(bus2.out_group), 136'(exp_grp_q.pop_front()));
            end
        end
    end

    // Timing logs for the latency-variant instances.
    int     s2_cyc1 = -1;
    int     s2_cyc5 = -1;
    int     ov_cyc1[$];
    int     ov_cyc5[$];
    group_t ov_dat1[$];
    group_t ov_dat5[$];

    always @(negedge clk) begin
        if (bus1.rotation == 3'b100 && s2_cyc1 < 0) s2_cyc1 = cyc;
        if (bus5.rotation == 3'b100 && s2_cyc5 < 0) s2_cyc5 = cyc;
        if (bus1.out_valid) begin ov_cyc1.push_back(cyc); ov_dat1.push_back(bus1.out_data); end
        if (bus5.out_valid) begin ov_cyc5.push_back(cyc); ov_dat5.push_back(bus5.out_data); end
    end

    // ---------------- driver tasks ----------------
    // Drives 16 samples; returns at the negedge of the first issue cycle.
    // c0 is the cyc value seen during that first issue cycle.
    task automatic drive_frame(input cplx_t s [16], output int c0);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        c0 = -1;
        while (idx < 16 && guard < 200) begin
            @(negedge clk);
            guard++;
            drv_valid = 1'b1;
            drv_data  = s[idx];
            if (bus2.in_ready) begin
                if (idx == 15) c0 = cyc + 1;
                idx++;
            end
        end
        @(negedge clk);
        drv_valid = 1'b0;
        if (idx < 16) check_eq("drive_timeout", 136'(idx), 136'(16));
    endtask

    // Full frame with cycle-exact checks of issue, output and ready timing.
    task automatic run_frame(input cplx_t s [16], input bit noise, output int c0);
        group_t     g [4];
        group_t     e_calc;
        logic [2:0] e_rot;
        logic       e_ov;
        logic       e_rdy;
        for (int k = 0; k < 4; k++) begin
            g[k] = {s[4*k], s[4*k+1], s[4*k+2], s[4*k+3]};
            exp_q.push_back(g[k]);
            exp_grp_q.push_back(2'(k));
        end
        drive_frame(s, c0);
        if (c0 >= 0) begin
            for (int n = 0; n <= 2*L+9; n++) begin
                if (n > 0) @(negedge clk);
                e_calc = '0;
                e_rot  = 3'b000;
                e_ov   = (n >= 2*L+5) && (n <= 2*L+8);
                e_rdy  = (n == 2*L+9);
                if (n < 4) begin
                    e_calc = g[n];
                    e_rot  = 3'(n);
                end else if (n >= L+4 && n <= L+7) begin
                    e_calc = g[n-L-4];
                    e_rot  = 3'(n-L);
                end
                if (noise && n >= L+4 && n <= L+7) begin
                    drv_valid = 1'b1;
                    drv_data  = {2'($urandom_range(3, 0)), 32'($urandom())};
                end else begin
                    drv_valid = 1'b0;
                end
                check_eq("calc_in", bus2.calc_in, e_calc);
                check_eq("rotation", 136'(bus2.rotation), 136'(e_rot));
                check_eq("out_valid_timing", 136'(bus2.out_valid), 136'(e_ov));
                check_eq("in_ready_timing", 136'(bus2.in_ready), 136'(e_rdy));
            end
        end
        drv_valid = 1'b0;
        check_eq("sb_drained", 136'(exp_q.size()), 136'(0));
    endtask

    task automatic run_throughput();
        cplx_t s [48];
        int    idx;
        int    pulses;
        int    run;
        int    guard;
        int    runs[$];
        idx = 0; pulses = 0; run = 0; guard = 0;
        for (int i = 0; i < 48; i++) s[i] = {17'(i*3 + 1), 17'(0 - i*5)};
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({s[16*f+4*k], s[16*f+4*k+1], s[16*f+4*k+2], s[16*f+4*k+3]});
                exp_grp_q.push_back(2'(k));
            end
        end
        while (guard < 400 && !(idx == 48 && pulses == 12 && bus2.in_ready)) begin
            @(negedge clk);
            guard++;
            if (bus2.out_valid) pulses++;
            if (!bus2.in_ready) run++;
            else if (run > 0) begin runs.push_back(run); run = 0; end
            if (idx < 48) begin
                drv_valid = 1'b1;
                drv_data  = s[idx];
                if (bus2.in_ready) idx++;
            end else begin
                drv_valid = 1'b0;
            end
        end
        drv_valid = 1'b0;
        check_eq("tp_accepts", 136'(idx), 136'(48));
        check_eq("tp_pulses", 136'(pulses), 136'(12));
        check_eq("tp_ready_gaps", 136'(runs.size()), 136'(3));
        foreach (runs[i]) check_eq("tp_ready_low_len", 136'(runs[i]), 136'(2*L+9));
        check_eq("tp_sb_drained", 136'(exp_q.size()), 136'(0));
    endtask

    // ---------------- stimulus ----------------
    group_t imp_g [4];

    initial begin
        cplx_t s [16];
        int    c0;
        int    c0_first;

        // Reset and reset values.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 136'(bus2.in_ready), 136'(1));
        check_eq("rst_calc_in", bus2.calc_in, 136'(0));
        check_eq("rst_rotation", 136'(bus2.rotation), 136'(0));
        check_eq("rst_out_valid", 136'(bus2.out_valid), 136'(0));
        check_eq("rst_out_data", bus2.out_data, 136'(0));
        check_eq("rst_out_group", 136'(bus2.out_group), 136'(0));

        // Impulse: 1.0 in sample 0, group 0 word is 136'h0080 followed by zeros.
        for (int i = 0; i < 16; i++) s[i] = '0;
        s[0] = {17'h00100, 17'h00000};
        imp_g[0] = 136'h0080_0000_0000_0000_0000_0000_0000_0000_00;
        for (int k = 1; k < 4; k++) imp_g[k] = '0;
        run_frame(s, 1'b0, c0_first);

        // Ordering: sample n = Re n<<8, Im -n.
        for (int n = 0; n < 16; n++) s[n] = {17'(n << 8), 17'(0 - n)};
        run_frame(s, 1'b0, c0);

        // Latency variants, measured on the impulse frame.
        check_eq("l1_s2_start", 136'(s2_cyc1 - c0_first), 136'(1 + 4));
        check_eq("l5_s2_start", 136'(s2_cyc5 - c0_first), 136'(5 + 4));
        if (ov_cyc1.size() < 4) check_eq("l1_ov_count", 136'(ov_cyc1.size()), 136'(4));
        else for (int k = 0; k < 4; k++) begin
            check_eq("l1_ov_cycle", 136'(ov_cyc1[k] - c0_first), 136'(2*1 + 5 + k));
            check_eq("l1_ov_data", ov_dat1[k], imp_g[k]);
        end
        if (ov_cyc5.size() < 4) check_eq("l5_ov_count", 136'(ov_cyc5.size()), 136'(4));
        else for (int k = 0; k < 4; k++) begin
            check_eq("l5_ov_cycle", 136'(ov_cyc5[k] - c0_first), 136'(2*5 + 5 + k));
            check_eq("l5_ov_data", ov_dat5[k], imp_g[k]);
        end

        // Ignored input during stage-2 issue, then a frame whose first sample
        // must be the first one accepted after in_ready rises.
        for (int n = 0; n < 16; n++) s[n] = {17'(16'hA000 + n), 17'(n * 7 + 3)};
        run_frame(s, 1'b1, c0);
        for (int n = 0; n < 16; n++) s[n] = {17'(17'h1F000 - n), 17'(n * 11)};
        run_frame(s, 1'b0, c0);

        // Three frames with in_valid held high.
        run_throughput();

        // Reset during stage-1 drain: partial frame must vanish.
        for (int n = 0; n < 16; n++) s[n] = {17'(n + 100), 17'(n + 200)};
        drive_frame(s, c0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_calc_in", bus2.calc_in, 136'(0));
        check_eq("midrst_rotation", 136'(bus2.rotation), 136'(0));
        check_eq("midrst_out_valid", 136'(bus2.out_valid), 136'(0));
        check_eq("midrst_out_data", bus2.out_data, 136'(0));
        check_eq("midrst_out_group", 136'(bus2.out_group), 136'(0));
        repeat (3) begin
            @(negedge clk);
            check_eq("midrst_hold_out_valid", 136'(bus2.out_valid), 136'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 136'(bus2.in_ready), 136'(1));
        for (int n = 0; n < 16; n++) s[n] = {17'(n * 257), 17'(17'h10000 | n)};
        run_frame(s, 1'b0, c0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
